l1_block_cache: RTL and testbench

Parametrised, fully associative, multi-port block cache between the renderer/physics read ports and chunk memory. Each of `N_PORTS` ports gets a single-cycle lookup of a `BlockPos`, returning `BlockType` and a hit flag. On a miss, one refill engine fetches the block from the backing store over a valid/ready request and valid response interface, then installs it with round-robin replacement. A write-update port keeps cached entries coherent with world edits.

---
 rtl/l1_block_cache.sv | 201 ++++++++++++++++++++
 tb/tb_l1_block_cache.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_block_cache.sv
// l1_block_cache: fully associative, multi-port block cache in front of chunk memory.
//
// Each lookup port compares its position against every valid tag in the same cycle and
// registers a hit flag plus the cached block type for the next cycle. A single refill
// engine serves misses one at a time, always choosing the lowest-index missing port. It
// fetches the block over a valid/ready request and a one-cycle response pulse, then installs
// it with round-robin replacement. World edits update matching cached entries in place.
//
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   req_valid, req_pos      per-port lookup request and queried position {x,y,z}
//   out_valid, out_type     per-port registered hit flag and block type (air when no hit)
//   mem_req_valid/ready/pos refill request handshake to the backing store
//   mem_resp_valid/type     refill response, one-cycle pulse
//   wr_valid/pos/type       world-edit update
//   busy                    refill engine is not idle
module l1_block_cache #(
  parameter int unsigned N_PORTS = 4,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned COORD_W = 8,
  parameter int unsigned TYPE_W  = 8
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic [N_PORTS-1:0]                   req_valid,
  input  logic [N_PORTS-1:0][3*COORD_W-1:0]    req_pos,
  output logic [N_PORTS-1:0]                   out_valid,
  output logic [N_PORTS-1:0][TYPE_W-1:0]       out_type,
  output logic                                 mem_req_valid,
  input  logic                                 mem_req_ready,
  output logic [3*COORD_W-1:0]                 mem_req_pos,
  input  logic                                 mem_resp_valid,
  input  logic [TYPE_W-1:0]                    mem_resp_type,
  input  logic                                 wr_valid,
  input  logic [3*COORD_W-1:0]                 wr_pos,
  input  logic [TYPE_W-1:0]                    wr_type,
  output logic                                 busy
);

  localparam int unsigned POS_W = 3 * COORD_W;
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [TYPE_W-1:0] BLOCK_AIR = '0;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StFill} state_e;

  state_e                          state_q;
  logic [ENTRIES-1:0]              valid_q;
  logic [ENTRIES-1:0][POS_W-1:0]   tag_q;
  logic [ENTRIES-1:0][TYPE_W-1:0]  data_q;
  logic [IDX_W-1:0]                victim_q;
  logic [TYPE_W-1:0]               fill_type_q;
  // Set once a world edit has hit the in-flight position; the edit then owns the data.
  logic                            override_q;

  // Lookup: at most one entry matches, so OR-ing the matching data is a clean mux.
  logic [N_PORTS-1:0]              hit;
  logic [N_PORTS-1:0][TYPE_W-1:0]  hit_type;

  always_comb begin
    hit      = '0;
    hit_type = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      for (int unsigned e = 0; e < ENTRIES; e++) begin
        if (valid_q[e] && (tag_q[e] == req_pos[p])) begin
          hit[p]      = 1'b1;
          hit_type[p] = hit_type[p] | data_q[e];
        end
      end
    end
  end

  // Lowest-index port with an outstanding miss.
  logic             miss_any;
  logic [POS_W-1:0] miss_pos;

  always_comb begin
    miss_any = 1'b0;
    miss_pos = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      if (!miss_any && req_valid[p] && !hit[p]) begin
        miss_any = 1'b1;
        miss_pos = req_pos[p];
      end
    end
  end

  // Install target: an entry already holding the fetched position is reused in place.
  logic             dedup_hit;
  logic [IDX_W-1:0] dedup_idx;

  always_comb begin
    dedup_hit = 1'b0;
    dedup_idx = '0;
    for (int unsigned e = 0; e < ENTRIES; e++) begin
      if (valid_q[e] && (tag_q[e] == mem_req_pos)) begin
        dedup_hit = 1'b1;
        dedup_idx = IDX_W'(e);
      end
    end
  end

  logic             wr_inflight;
  logic [TYPE_W-1:0] fill_data;
  logic [IDX_W-1:0] fill_idx;

  assign wr_inflight = wr_valid && (wr_pos == mem_req_pos);
  // An edit landing on the FILL edge still wins over the latched data.
  assign fill_data   = wr_inflight ? wr_type : fill_type_q;
  assign fill_idx    = dedup_hit ? dedup_idx : victim_q;

  // Storage and replacement pointer.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q  <= '0;
      tag_q    <= '0;
      data_q   <= '0;
      victim_q <= '0;
    end else begin
      for (int unsigned e = 0; e < ENTRIES; e++) begin
        if (wr_valid && valid_q[e] && (tag_q[e] == wr_pos)) begin
          data_q[e] <= wr_type;
        end
      end
      // Later assignment takes priority over a write-update to the evicted entry.
      if (state_q == StFill) begin
        valid_q[fill_idx] <= 1'b1;
        tag_q[fill_idx]   <= mem_req_pos;
        data_q[fill_idx]  <= fill_data;
        if (!dedup_hit) begin
          victim_q <= victim_q + IDX_W'(1);
        end
      end
    end
  end

  // Registered lookup results.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      out_valid <= '0;
      out_type  <= '0;
    end else begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        out_valid[p] <= req_valid[p] && hit[p];
        out_type[p]  <= (req_valid[p] && hit[p]) ? hit_type[p] : BLOCK_AIR;
      end
    end
  end

  // Refill engine.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= StIdle;
      mem_req_valid <= 1'b0;
      mem_req_pos   <= '0;
      busy          <= 1'b0;
      fill_type_q   <= BLOCK_AIR;
      override_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          override_q <= 1'b0;
          if (miss_any) begin
            mem_req_pos   <= miss_pos;
            mem_req_valid <= 1'b1;
            busy          <= 1'b1;
            state_q       <= StReq;
          end
        end
        StReq: begin
          if (wr_inflight) begin
            fill_type_q <= wr_type;
            override_q  <= 1'b1;
          end
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state_q       <= StWait;
          end
        end
        StWait: begin
          if (wr_inflight) begin
            fill_type_q <= wr_type;
            override_q  <= 1'b1;
          end else if (mem_resp_valid && !override_q) begin
            fill_type_q <= mem_resp_type;
          end
          if (mem_resp_valid) begin
            state_q <= StFill;
          end
        end
        StFill: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_block_cache.sv
// Self-checking bench for l1_block_cache: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level cache model.
module tb_l1_block_cache;

  localparam int N  = 4;
  localparam int E  = 16;
  localparam int C  = 8;
  localparam int T  = 8;
  localparam int PW = 3 * C;

  localparam int PH_IDLE = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_WAIT = 2;
  localparam int PH_FILL = 3;

  logic                   clk_in;
  logic                   rst_in;
  logic [N-1:0]           req_valid;
  logic [N-1:0][PW-1:0]   req_pos;
  logic [N-1:0]           out_valid;
  logic [N-1:0][T-1:0]    out_type;
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic [PW-1:0]          mem_req_pos;
  logic                   mem_resp_valid;
  logic [T-1:0]           mem_resp_type;
  logic                   wr_valid;
  logic [PW-1:0]          wr_pos;
  logic [T-1:0]           wr_type;
  logic                   busy;

  l1_block_cache #(
    .N_PORTS(N),
    .ENTRIES(E),
    .COORD_W(C),
    .TYPE_W (T)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_valid     (req_valid),
    .req_pos       (req_pos),
    .out_valid     (out_valid),
    .out_type      (out_type),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_pos   (mem_req_pos),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_type (mem_resp_type),
    .wr_valid      (wr_valid),
    .wr_pos        (wr_pos),
    .wr_type       (wr_type),
    .busy          (busy)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int vectors     = 0;
  int miscompares = 0;
  int n_checks    = 0;
  int hs_count    = 0;

  // Reference model: slot arrays plus the refill transaction in flight.
  bit          m_valid [E];
  logic [PW-1:0] m_tag [E];
  logic [T-1:0]  m_data[E];
  int          m_victim;
  int          m_phase;
  logic [PW-1:0] m_pos;
  logic [T-1:0]  m_type;
  bit          m_edited;

  logic [N-1:0]        e_ov;
  logic [N-1:0][T-1:0] e_ot;

  function automatic logic [PW-1:0] mkpos(input int x, input int y, input int z);
    logic [C-1:0] a, b, c;
    a = x[C-1:0];
    b = y[C-1:0];
    c = z[C-1:0];
    return {a, b, c};
  endfunction

  function automatic int find(input logic [PW-1:0] pos);
    for (int i = 0; i < E; i++) begin
      if (m_valid[i] && m_tag[i] == pos) return i;
    end
    return -1;
  endfunction

  task automatic model_step();
    int  idx;
    bit  edit_hits_pending;
    logic [T-1:0] data;
    if (rst_in) begin
      for (int i = 0; i < E; i++) begin
        m_valid[i] = 0;
        m_tag[i]   = '0;
        m_data[i]  = '0;
      end
      m_victim = 0;
      m_phase  = PH_IDLE;
      m_pos    = '0;
      m_type   = '0;
      m_edited = 0;
      e_ov     = '0;
      e_ot     = '0;
      return;
    end
    for (int p = 0; p < N; p++) begin
      idx     = find(req_pos[p]);
      e_ov[p] = req_valid[p] && (idx >= 0);
      e_ot[p] = e_ov[p] ? m_data[idx] : '0;
    end
    edit_hits_pending = wr_valid && (wr_pos == m_pos) && (m_phase != PH_IDLE);
    // Edits only change data, never tags, so doing them first leaves hit/miss untouched.
    if (wr_valid) begin
      idx = find(wr_pos);
      if (idx >= 0) m_data[idx] = wr_type;
    end
    case (m_phase)
      PH_IDLE: begin
        for (int p = N - 1; p >= 0; p--) begin
          if (req_valid[p] && find(req_pos[p]) < 0) begin
            m_pos   = req_pos[p];
            m_phase = PH_REQ;
          end
        end
        m_edited = 0;
      end
      PH_REQ: begin
        if (edit_hits_pending) begin
          m_type   = wr_type;
          m_edited = 1;
        end
        if (mem_req_ready) m_phase = PH_WAIT;
      end
      PH_WAIT: begin
        if (mem_resp_valid && !m_edited) m_type = mem_resp_type;
        if (edit_hits_pending) begin
          m_type   = wr_type;
          m_edited = 1;
        end
        if (mem_resp_valid) m_phase = PH_FILL;
      end
      default: begin
        data = edit_hits_pending ? wr_type : m_type;
        idx  = find(m_pos);
        if (idx >= 0) begin
          m_data[idx] = data;
        end else begin
          m_valid[m_victim] = 1;
          m_tag[m_victim]   = m_pos;
          m_data[m_victim]  = data;
          m_victim          = (m_victim + 1) % E;
        end
        m_phase = PH_IDLE;
      end
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    if (mem_req_valid && mem_req_ready) hs_count++;
    @(posedge clk_in);
    model_step();
    #1;
    vectors++;
    for (int p = 0; p < N; p++) begin
      chk($sformatf("model out_valid[%0d]", p), 32'(out_valid[p]), 32'(e_ov[p]));
      chk($sformatf("model out_type[%0d]", p), 32'(out_type[p]), 32'(e_ot[p]));
    end
    chk("model mem_req_valid", 32'(mem_req_valid), 32'(m_phase == PH_REQ));
    chk("model mem_req_pos", 32'(mem_req_pos), 32'(m_pos));
    chk("model busy", 32'(busy), 32'(m_phase != PH_IDLE));
  endtask

  task automatic clear_inputs();
    req_valid      = '0;
    req_pos        = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_type  = '0;
    wr_valid       = 1'b0;
    wr_pos         = '0;
    wr_type        = '0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (m_phase != PH_REQ && n < 50) begin
      tick();
      n++;
    end
    if (m_phase != PH_REQ) begin
      miscompares++;
      $display("FAIL wait_req: refill request not reached within 50 cycles");
    end
  endtask

  // From REQ: accept, respond with t, then FILL -> IDLE.
  task automatic serve(input logic [T-1:0] t);
    mem_req_ready  = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_type  = t;
    tick();
    mem_resp_valid = 1'b0;
    tick();
  endtask

  initial begin
    int x, y, z;
    clear_inputs();
    rst_in = 1'b1;

    // Reset
    tick();
    tick();
    chk("rst out_valid", 32'(out_valid), 32'h0);
    chk("rst out_type", 32'(out_type), 32'h0);
    chk("rst mem_req_valid", 32'(mem_req_valid), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    rst_in       = 1'b0;
    req_valid[0] = 1'b1;
    req_pos[0]   = mkpos(0, 0, 0);
    tick();
    chk("zero lookup out_valid", 32'(out_valid[0]), 32'h0);
    chk("zero lookup mem_req_valid", 32'(mem_req_valid), 32'h1);
    req_valid = '0;
    do_reset();

    // Cold miss
    req_valid[0] = 1'b1;
    req_pos[0]   = mkpos(1, 2, 3);
    tick();
    chk("cold mem_req_valid", 32'(mem_req_valid), 32'h1);
    chk("cold mem_req_pos", 32'(mem_req_pos), 32'h010203);
    mem_req_ready  = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_type  = 8'd5;
    tick();
    mem_resp_valid = 1'b0;
    chk("cold busy in fill", 32'(busy), 32'h1);
    tick();
    chk("cold r+2 out_valid", 32'(out_valid[0]), 32'h0);
    tick();
    chk("cold r+3 out_valid", 32'(out_valid[0]), 32'h1);
    chk("cold r+3 out_type", 32'(out_type[0]), 32'h5);
    req_valid = '0;
    do_reset();

    // Multi-port: two ports share a position, one port differs
    hs_count   = 0;
    req_valid  = 4'b0111;
    req_pos[0] = mkpos(-4, 7, 1);
    req_pos[1] = mkpos(9, 9, 9);
    req_pos[2] = mkpos(-4, 7, 1);
    tick();
    chk("multi first pos", 32'(mem_req_pos), 32'hfc0701);
    serve(8'd11);
    wait_req();
    chk("multi second pos", 32'(mem_req_pos), 32'h090909);
    serve(8'd12);
    tick();
    chk("multi out_valid", 32'(out_valid), 32'h7);
    chk("multi out_type", 32'(out_type), 32'h000b0c0b);
    chk("multi request count", 32'(hs_count), 32'h2);
    req_valid = '0;
    do_reset();

    // Round-robin wrap over ENTRIES+1 distinct positions
    req_valid[0] = 1'b1;
    for (int k = 0; k <= E; k++) begin
      req_pos[0] = mkpos(k, 1, 2);
      wait_req();
      serve(T'(k + 1));
    end
    req_pos[0] = mkpos(0, 1, 2);
    tick();
    chk("wrap first evicted", 32'(out_valid[0]), 32'h0);
    chk("wrap refill issued", 32'(mem_req_valid), 32'h1);
    serve(8'd50);
    for (int k = 2; k <= E; k++) begin
      req_pos[0] = mkpos(k, 1, 2);
      tick();
      chk($sformatf("wrap hit %0d", k), 32'(out_valid[0]), 32'h1);
      chk($sformatf("wrap type %0d", k), 32'(out_type[0]), 32'(k + 1));
    end
    req_pos[0] = mkpos(1, 1, 2);
    tick();
    chk("wrap victim was entry 1", 32'(out_valid[0]), 32'h0);
    req_valid = '0;
    do_reset();

    // Write-update
    req_valid[0] = 1'b1;
    req_pos[0]   = mkpos(1, 1, 1);
    wait_req();
    serve(8'd5);
    wr_valid = 1'b1;
    wr_pos   = mkpos(1, 1, 1);
    wr_type  = 8'd9;
    tick();
    wr_valid = 1'b0;
    chk("write same-cycle lookup old data", 32'(out_type[0]), 32'h5);
    tick();
    chk("write lookup new data", 32'(out_type[0]), 32'h9);
    req_valid = '0;
    wr_valid  = 1'b1;
    wr_pos    = mkpos(2, 2, 2);
    wr_type   = 8'd3;
    tick();
    wr_valid = 1'b0;
    chk("uncached write no refill", 32'(busy), 32'h0);
    req_valid[0] = 1'b1;
    req_pos[0]   = mkpos(2, 2, 2);
    tick();
    chk("uncached write no allocate", 32'(out_valid[0]), 32'h0);
    req_valid = '0;
    do_reset();

    // Edit to the in-flight position in the response cycle wins
    req_valid[0] = 1'b1;
    req_pos[0]   = mkpos(5, 5, 5);
    wait_req();
    mem_req_ready  = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_type  = 8'd44;
    wr_valid       = 1'b1;
    wr_pos         = mkpos(5, 5, 5);
    wr_type        = 8'd33;
    tick();
    mem_resp_valid = 1'b0;
    wr_valid       = 1'b0;
    tick();
    tick();
    chk("inflight edit installed", 32'(out_type[0]), 32'd33);
    req_valid = '0;
    do_reset();

    // Reset mid-WAIT, late response ignored
    req_valid[0] = 1'b1;
    req_pos[0]   = mkpos(3, 3, 3);
    wait_req();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst_in        = 1'b1;
    tick();
    rst_in        = 1'b0;
    chk("midwait rst busy", 32'(busy), 32'h0);
    chk("midwait rst mem_req_valid", 32'(mem_req_valid), 32'h0);
    mem_resp_valid = 1'b1;
    mem_resp_type  = 8'd7;
    tick();
    mem_resp_valid = 1'b0;
    chk("midwait not installed", 32'(out_valid[0]), 32'h0);
    chk("midwait fresh request", 32'(mem_req_valid), 32'h1);
    chk("midwait fresh pos", 32'(mem_req_pos), 32'h030303);
    serve(8'd8);
    tick();
    chk("midwait refetched type", 32'(out_type[0]), 32'h8);
    clear_inputs();
    do_reset();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < N; p++) begin
        req_valid[p] = 1'($urandom_range(0, 1));
        x = int'($urandom_range(0, 2)) - 1;
        y = int'($urandom_range(0, 2)) - 1;
        z = int'($urandom_range(0, 2)) - 1;
        req_pos[p] = mkpos(x, y, z);
      end
      mem_req_ready  = 1'($urandom_range(0, 1));
      mem_resp_valid = ($urandom_range(0, 9) < 4);
      mem_resp_type  = T'($urandom);
      wr_valid       = ($urandom_range(0, 9) < 2);
      x = int'($urandom_range(0, 2)) - 1;
      y = int'($urandom_range(0, 2)) - 1;
      z = int'($urandom_range(0, 2)) - 1;
      wr_pos         = mkpos(x, y, z);
      wr_type        = T'($urandom);
      rst_in         = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
